// File: rtl/loop_pkg.sv
// Shared constants, helpers and the level record for the nested-loop address generator.
package loop_pkg;

    // Default configuration.
    localparam int unsigned DefBits        = 18;
    localparam int unsigned DefLoopLogCnt  = 3;
    localparam int unsigned DefSsLogWidth  = 2;
    localparam int unsigned DefAddrBits    = 18;
    localparam int unsigned DefAddrCh      = 3;

    function automatic int unsigned pow2(input int unsigned l);
        return 32'd1 << l;
    endfunction

    // Stack depth and issue width derived from their log2 forms.
    localparam int unsigned DefLoopCnt = pow2(DefLoopLogCnt);
    localparam int unsigned DefW       = pow2(DefSsLogWidth);

    // Copies available this issue group, capped at the issue width.
    function automatic int unsigned min_w(input int unsigned rem, input int unsigned w);
        return (rem < w) ? rem : w;
    endfunction

    // One stack entry in the default configuration.
    typedef struct packed {
        logic [DefBits-1:0]                    rem;
        logic                                  ind;
        logic [DefAddrCh-1:0][DefAddrBits-1:0] acc;
        logic [DefAddrCh-1:0][DefAddrBits-1:0] str;
    } level_t;

endpackage

// File: rtl/loop_level.sv
// One loop-stack entry: iteration counter, independence flag and per-stream accumulators.
module loop_level
    import loop_pkg::*;
#(
    parameter int unsigned BITS                  = DefBits,
    parameter int unsigned SUPERSCALAR_LOG_WIDTH = DefSsLogWidth,
    parameter int unsigned ADDR_BITS             = DefAddrBits,
    parameter int unsigned ADDR_CH               = DefAddrCh
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_i,
    input  logic                             step_i,
    input  logic [BITS-1:0]                  count_i,
    input  logic                             ind_i,
    input  logic [ADDR_CH*ADDR_BITS-1:0]     base_i,
    input  logic [ADDR_CH*ADDR_BITS-1:0]     stride_i,
    output logic [BITS-1:0]                  rem_o,
    output logic                             ind_o,
    output logic [ADDR_CH*ADDR_BITS-1:0]     acc_o,
    output logic [SUPERSCALAR_LOG_WIDTH:0]   n_o
);

    localparam int unsigned W  = pow2(SUPERSCALAR_LOG_WIDTH);
    localparam int unsigned NW = SUPERSCALAR_LOG_WIDTH + 1;

    logic [BITS-1:0]      rem_q, rem_d;
    logic                 ind_q, ind_d;
    logic [ADDR_BITS-1:0] acc_q [ADDR_CH];
    logic [ADDR_BITS-1:0] acc_d [ADDR_CH];
    logic [ADDR_BITS-1:0] str_q [ADDR_CH];
    logic [ADDR_BITS-1:0] str_d [ADDR_CH];
    logic [ADDR_BITS-1:0] inc   [ADDR_CH];
    logic [NW-1:0]        n;

    // Copies in this issue group: up to W when independent, else one; none once exhausted.
    always_comb begin
        if (ind_q) n = NW'(min_w(32'(rem_q), W));
        else       n = (rem_q != '0) ? NW'(1) : '0;
    end

    // stride*n as a shift-add over the bits of n, wrapping at ADDR_BITS.
    always_comb begin
        for (int c = 0; c < ADDR_CH; c++) begin
            inc[c] = '0;
            for (int b = 0; b < NW; b++) begin
                if (n[b]) inc[c] = inc[c] + (str_q[c] << b);
            end
        end
    end

    // Load a fresh loop or advance by one issue group; n never exceeds rem so no underflow.
    always_comb begin
        rem_d = rem_q;
        ind_d = ind_q;
        for (int c = 0; c < ADDR_CH; c++) begin
            acc_d[c] = acc_q[c];
            str_d[c] = str_q[c];
        end
        if (load_i) begin
            rem_d = count_i;
            ind_d = ind_i;
            for (int c = 0; c < ADDR_CH; c++) begin
                acc_d[c] = base_i[c*ADDR_BITS +: ADDR_BITS];
                str_d[c] = stride_i[c*ADDR_BITS +: ADDR_BITS];
            end
        end else if (step_i) begin
            rem_d = rem_q - BITS'(n);
            for (int c = 0; c < ADDR_CH; c++) begin
                acc_d[c] = acc_q[c] + inc[c];
            end
        end
    end

    // Entry state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            ind_q <= 1'b0;
            for (int c = 0; c < ADDR_CH; c++) begin
                acc_q[c] <= '0;
                str_q[c] <= '0;
            end
        end else begin
            rem_q <= rem_d;
            ind_q <= ind_d;
            for (int c = 0; c < ADDR_CH; c++) begin
                acc_q[c] <= acc_d[c];
                str_q[c] <= str_d[c];
            end
        end
    end

    for (genvar c = 0; c < ADDR_CH; c++) begin : g_acc
        assign acc_o[c*ADDR_BITS +: ADDR_BITS] = acc_q[c];
    end

    assign rem_o = rem_q;
    assign ind_o = ind_q;
    assign n_o   = n;

endmodule

// File: rtl/loop_stack_agu.sv
// Nested-loop stack with per-level address generation; outputs follow the top-of-stack entry.
// Optional perf counters (perf_issued, perf_stall) are built when LOOP_STACK_PERF_EN is defined.
module loop_stack_agu
    import loop_pkg::*;
#(
    parameter int unsigned BITS                  = DefBits,
    parameter int unsigned LOOP_LOG_CNT          = DefLoopLogCnt,
    parameter int unsigned SUPERSCALAR_LOG_WIDTH = DefSsLogWidth,
    parameter int unsigned ADDR_BITS             = DefAddrBits,
    parameter int unsigned ADDR_CH               = DefAddrCh
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               push,
    input  logic [BITS-1:0]                    push_count,
    input  logic                               push_independent,
    input  logic [ADDR_CH*ADDR_BITS-1:0]       push_base,
    input  logic [ADDR_CH*ADDR_BITS-1:0]       push_stride,
    input  logic                               step,
    input  logic                               pop,
    output logic                               push_ready,
    output logic [LOOP_LOG_CNT:0]              depth,
    output logic                               done,
    output logic [SUPERSCALAR_LOG_WIDTH-1:0]   copy_count,
    output logic [ADDR_CH*ADDR_BITS-1:0]       addr,
    output logic                               err
`ifdef LOOP_STACK_PERF_EN
    ,
    output logic [31:0]                        perf_issued,
    output logic [31:0]                        perf_stall
`endif
);

    localparam int unsigned LoopCnt = pow2(LOOP_LOG_CNT);
    localparam int unsigned W       = pow2(SUPERSCALAR_LOG_WIDTH);
    localparam int unsigned NW      = SUPERSCALAR_LOG_WIDTH + 1;
    localparam int unsigned DW      = LOOP_LOG_CNT + 1;

    logic [DW-1:0]                  depth_q, depth_d;
    logic                           err_q, err_d;
    logic [LoopCnt-1:0]             load, stepv;
    logic [LOOP_LOG_CNT-1:0]        top_idx;

    logic [BITS-1:0]                lvl_rem [LoopCnt];
    logic                           lvl_ind [LoopCnt];
    logic [ADDR_CH*ADDR_BITS-1:0]   lvl_acc [LoopCnt];
    logic [NW-1:0]                  lvl_n   [LoopCnt];

    assign top_idx    = LOOP_LOG_CNT'(depth_q - DW'(1));
    assign push_ready = depth_q < DW'(LoopCnt);

    // Command decode: pop > push > step; pop+push reloads the vacated top slot.
    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        load    = '0;
        stepv   = '0;
        if (!stall) begin
            if (pop) begin
                if (depth_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    depth_d = depth_q - DW'(1);
                    if (push) begin
                        if (push_count == '0) begin
                            err_d = 1'b1;
                        end else begin
                            load[top_idx] = 1'b1;
                            depth_d       = depth_q;
                        end
                    end
                end
            end else if (push) begin
                if (!push_ready || push_count == '0) begin
                    err_d = 1'b1;
                end else begin
                    load[depth_q[LOOP_LOG_CNT-1:0]] = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end else if (step) begin
                if (depth_q == '0) err_d = 1'b1;
                else               stepv[top_idx] = 1'b1;
            end
        end
    end

    // Depth and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < LoopCnt; g++) begin : g_level
        loop_level #(
            .BITS                  (BITS),
            .SUPERSCALAR_LOG_WIDTH (SUPERSCALAR_LOG_WIDTH),
            .ADDR_BITS             (ADDR_BITS),
            .ADDR_CH               (ADDR_CH)
        ) u_level (
            .clk      (clk),
            .reset    (reset),
            .load_i   (load[g]),
            .step_i   (stepv[g]),
            .count_i  (push_count),
            .ind_i    (push_independent),
            .base_i   (push_base),
            .stride_i (push_stride),
            .rem_o    (lvl_rem[g]),
            .ind_o    (lvl_ind[g]),
            .acc_o    (lvl_acc[g]),
            .n_o      (lvl_n[g])
        );
    end

    // Present the top-of-stack entry; everything reads zero while empty.
    always_comb begin
        done       = 1'b0;
        copy_count = '0;
        addr       = '0;
        if (depth_q != '0) begin
            addr = lvl_acc[top_idx];
            if (lvl_n[top_idx] != '0) begin
                copy_count = SUPERSCALAR_LOG_WIDTH'(lvl_n[top_idx] - NW'(1));
            end
            if (lvl_ind[top_idx]) begin
                done = (lvl_rem[top_idx] != '0) && (lvl_rem[top_idx] <= BITS'(W));
            end else begin
                done = lvl_rem[top_idx] == BITS'(1);
            end
        end
    end

    assign depth = depth_q;
    assign err   = err_q;

`ifdef LOOP_STACK_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Accumulate copies issued by accepted steps and cycles spent stalled.
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (stall) perf_stall_d = perf_stall_q + 32'd1;
        if (|stepv) perf_issued_d = perf_issued_q + 32'(lvl_n[top_idx]);
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_loop_stack_agu.sv
// Self-checking bench for loop_stack_agu against a behavioural loop-stack model.
module tb_loop_stack_agu;

    localparam int LC = 8;
    localparam int W  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, push, push_independent, step, pop;
    logic [17:0] push_count;
    logic [53:0] push_base, push_stride;
    logic        push_ready, done, err;
    logic [3:0]  depth;
    logic [1:0]  copy_count;
    logic [53:0] addr;
`ifdef LOOP_STACK_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_depth;
    bit          m_err;
    int          m_rem [LC];
    bit          m_ind [LC];
    logic [17:0] m_acc [LC][3];
    logic [17:0] m_str [LC][3];
    int unsigned m_issued, m_stalls;

    always #5 clk = ~clk;

    loop_stack_agu dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .push             (push),
        .push_count       (push_count),
        .push_independent (push_independent),
        .push_base        (push_base),
        .push_stride      (push_stride),
        .step             (step),
        .pop              (pop),
        .push_ready       (push_ready),
        .depth            (depth),
        .done             (done),
        .copy_count       (copy_count),
        .addr             (addr),
        .err              (err)
`ifdef LOOP_STACK_PERF_EN
        ,
        .perf_issued      (perf_issued),
        .perf_stall       (perf_stall)
`endif
    );

    function automatic logic [53:0] pack3(input logic [17:0] a, b, c);
        return {c, b, a};
    endfunction

    function automatic logic [53:0] exp_addr();
        if (m_depth == 0) return '0;
        return {m_acc[m_depth-1][2], m_acc[m_depth-1][1], m_acc[m_depth-1][0]};
    endfunction

    function automatic logic exp_done();
        int r;
        if (m_depth == 0) return 1'b0;
        r = m_rem[m_depth-1];
        if (r == 0) return 1'b0;
        return m_ind[m_depth-1] ? (r <= W) : (r == 1);
    endfunction

    function automatic logic [1:0] exp_cc();
        int r;
        if (m_depth == 0) return 2'd0;
        r = m_rem[m_depth-1];
        if (!m_ind[m_depth-1] || r == 0) return 2'd0;
        return 2'((r < W ? r : W) - 1);
    endfunction

    function automatic bit top_exhausted();
        return m_depth > 0 && m_rem[m_depth-1] == 0;
    endfunction

    function automatic void model_load(input int lvl, input int cnt, input bit ind,
                                       input logic [53:0] b, input logic [53:0] s);
        m_rem[lvl] = cnt;
        m_ind[lvl] = ind;
        for (int c = 0; c < 3; c++) begin
            m_acc[lvl][c] = b[c*18 +: 18];
            m_str[lvl][c] = s[c*18 +: 18];
        end
    endfunction

    function automatic void model_apply(input bit s, po, pu, st, input int cnt, input bit ind,
                                        input logic [53:0] b, input logic [53:0] sr);
        int t, n;
        if (s) begin
            m_stalls++;
            return;
        end
        if (po) begin
            if (m_depth == 0) m_err = 1;
            else begin
                m_depth--;
                if (pu) begin
                    if (cnt == 0) m_err = 1;
                    else begin
                        model_load(m_depth, cnt, ind, b, sr);
                        m_depth++;
                    end
                end
            end
        end else if (pu) begin
            if (m_depth == LC || cnt == 0) m_err = 1;
            else begin
                model_load(m_depth, cnt, ind, b, sr);
                m_depth++;
            end
        end else if (st) begin
            if (m_depth == 0) m_err = 1;
            else begin
                t = m_depth - 1;
                n = m_ind[t] ? (m_rem[t] < W ? m_rem[t] : W) : 1;
                m_rem[t] = (m_rem[t] > n) ? m_rem[t] - n : 0;
                for (int c = 0; c < 3; c++) m_acc[t][c] = m_acc[t][c] + 18'(m_str[t][c] * n);
                m_issued += n;
            end
        end
    endfunction

    task automatic tick(input bit s, po, pu, st, input int cnt, input bit ind,
                        input logic [53:0] b, input logic [53:0] sr);
        stall = s; pop = po; push = pu; step = st;
        push_count = 18'(cnt); push_independent = ind; push_base = b; push_stride = sr;
        @(posedge clk);
        #1;
        model_apply(s, po, pu, st, cnt, ind, b, sr);
        stall = 0; pop = 0; push = 0; step = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_depth = 0; m_err = 0; m_issued = 0; m_stalls = 0;
        for (int l = 0; l < LC; l++) model_load(l, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        tick(0, 0, 1, 0, 5, 1, pack3(1, 2, 3), pack3(1, 1, 1));
        do_reset();
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", depth); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (done !== 1'b0 || copy_count !== 2'd0 || addr !== 54'd0)
            begin errors++; $display("FAIL reset_outs got done=%b cc=%0d addr=%h want 0", done, copy_count, addr); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", push_ready); end
    endtask

    task automatic test_basic();
        logic [17:0] want [4];
        logic        wdone [4];
        want = '{100, 104, 108, 112};
        wdone = '{0, 0, 1, 0};
        do_reset();
        tick(0, 0, 1, 0, 3, 0, pack3(100, 500, 7), pack3(4, 10, 262143));
        for (int i = 0; i < 4; i++) begin
            checks++; if (addr[17:0] !== want[i])
                begin errors++; $display("FAIL basic_addr%0d got %0d want %0d", i, addr[17:0], want[i]); end
            checks++; if (addr !== exp_addr())
                begin errors++; $display("FAIL basic_addr_all%0d got %h want %h", i, addr, exp_addr()); end
            checks++; if (done !== wdone[i] || copy_count !== 2'd0)
                begin errors++; $display("FAIL basic_done%0d got done=%b cc=%0d want done=%b cc=0", i, done, copy_count, wdone[i]); end
            if (i < 3) tick(0, 0, 0, 1, 0, 0, '0, '0);
        end
        tick(0, 1, 0, 0, 0, 0, '0, '0);
        checks++; if (depth !== 4'd0 || err !== 1'b0)
            begin errors++; $display("FAIL basic_pop got depth=%0d err=%b want 0 0", depth, err); end
    endtask

    task automatic test_independent();
        logic [1:0]  wcc [3];
        logic        wdone [3];
        logic [17:0] wad [4];
        wcc = '{3, 3, 1};
        wdone = '{0, 0, 1};
        wad = '{1000, 1012, 1024, 1030};
        do_reset();
        tick(0, 0, 1, 0, 10, 1, pack3(1000, 0, 50), pack3(3, 7, 262000));
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                checks++; if (copy_count !== wcc[i] || done !== wdone[i])
                    begin errors++; $display("FAIL ind_cc%0d got cc=%0d done=%b want cc=%0d done=%b", i, copy_count, done, wcc[i], wdone[i]); end
            end else begin
                checks++; if (done !== 1'b0)
                    begin errors++; $display("FAIL ind_done_exhausted got %b want 0", done); end
            end
            checks++; if (addr[17:0] !== wad[i] || addr !== exp_addr())
                begin errors++; $display("FAIL ind_addr%0d got %h want %h", i, addr, exp_addr()); end
            if (i < 3) tick(0, 0, 0, 1, 0, 0, '0, '0);
        end
    endtask

    task automatic test_nested();
        do_reset();
        tick(0, 0, 1, 0, 2, 0, pack3(0, 0, 0), pack3(100, 100, 100));
        tick(0, 0, 1, 0, 2, 0, pack3(7, 7, 7), pack3(1, 1, 1));
        checks++; if (addr[17:0] !== 18'd7 || depth !== 4'd2)
            begin errors++; $display("FAIL nest_inner got addr=%0d depth=%0d want 7 2", addr[17:0], depth); end
        tick(0, 0, 0, 1, 0, 0, '0, '0);
        tick(0, 0, 0, 1, 0, 0, '0, '0);
        tick(0, 1, 0, 0, 0, 0, '0, '0);
        checks++; if (addr !== 54'd0 || depth !== 4'd1)
            begin errors++; $display("FAIL nest_outer_hold got addr=%h depth=%0d want 0 1", addr, depth); end
        tick(0, 0, 0, 1, 0, 0, '0, '0);
        checks++; if (addr !== pack3(100, 100, 100) || depth !== 4'd1 || done !== 1'b1)
            begin errors++; $display("FAIL nest_outer_step got addr=%h depth=%0d done=%b want %h 1 1", addr, depth, done, pack3(100, 100, 100)); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < LC; i++) tick(0, 0, 1, 0, i + 1, i[0], pack3(18'(i), 0, 0), pack3(1, 1, 1));
        checks++; if (push_ready !== 1'b0 || depth !== 4'd8 || err !== 1'b0)
            begin errors++; $display("FAIL full got ready=%b depth=%0d err=%b want 0 8 0", push_ready, depth, err); end
        checks++; if (addr !== exp_addr())
            begin errors++; $display("FAIL full_addr got %h want %h", addr, exp_addr()); end
        tick(0, 0, 1, 0, 3, 0, '0, '0);
        checks++; if (err !== 1'b1 || depth !== 4'd8 || addr[17:0] !== 18'd7)
            begin errors++; $display("FAIL overflow got err=%b depth=%0d addr=%0d want 1 8 7", err, depth, addr[17:0]); end
        do_reset();
        tick(0, 0, 1, 0, 1, 0, '0, '0);
        tick(0, 1, 0, 0, 0, 0, '0, '0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pop_ok got err=%b want 0", err); end
        tick(0, 1, 0, 0, 0, 0, '0, '0);
        checks++; if (err !== 1'b1 || depth !== 4'd0)
            begin errors++; $display("FAIL pop_empty got err=%b depth=%0d want 1 0", err, depth); end
    endtask

    task automatic test_replace_stall();
        logic [53:0] held;
        do_reset();
        tick(0, 0, 1, 0, 4, 0, pack3(10, 10, 10), pack3(1, 1, 1));
        tick(0, 0, 1, 0, 4, 0, pack3(20, 20, 20), pack3(1, 1, 1));
        tick(0, 1, 1, 0, 6, 1, pack3(333, 444, 555), pack3(2, 2, 2));
        checks++; if (depth !== 4'd2 || addr !== pack3(333, 444, 555) || err !== 1'b0 || copy_count !== 2'd3)
            begin errors++; $display("FAIL replace got depth=%0d addr=%h err=%b cc=%0d want 2 %h 0 3", depth, addr, err, copy_count, pack3(333, 444, 555)); end
        tick(0, 0, 1, 0, 0, 0, '0, '0);
        checks++; if (err !== 1'b1 || depth !== 4'd2)
            begin errors++; $display("FAIL zero_count got err=%b depth=%0d want 1 2", err, depth); end
        do_reset();
        tick(0, 0, 1, 0, 5, 0, pack3(50, 60, 70), pack3(5, 5, 5));
        tick(0, 0, 0, 1, 0, 0, '0, '0);
        held = addr;
        tick(1, 0, 0, 1, 0, 0, '0, '0);
        tick(1, 1, 0, 0, 0, 0, '0, '0);
        checks++; if (addr !== held || addr !== pack3(55, 65, 75) || depth !== 4'd1 || done !== exp_done())
            begin errors++; $display("FAIL stall_hold got addr=%h depth=%0d done=%b want %h 1 %b", addr, depth, done, pack3(55, 65, 75), exp_done()); end
        do_reset();
        tick(1, 1, 0, 0, 0, 0, '0, '0);
        tick(1, 0, 1, 0, 0, 0, '0, '0);
        checks++; if (err !== 1'b0 || depth !== 4'd0)
            begin errors++; $display("FAIL stall_noerr got err=%b depth=%0d want 0 0", err, depth); end
    endtask

    task automatic test_random();
        bit s, po, pu, st, ind;
        int r, cnt;
        logic [53:0] b, sr;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            s = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 99);
            po = 0; pu = 0; st = 0;
            if (r < 20) po = 1;
            else if (r < 45) pu = 1;
            else st = 1;
            if (po && m_depth > 0 && $urandom_range(0, 3) == 0) pu = 1;
            if (st && top_exhausted()) begin st = 0; po = 1; end
            cnt = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 13);
            ind = $urandom_range(0, 1) == 1;
            b  = {$urandom, $urandom};
            sr = {$urandom, $urandom};
            tick(s, po, pu, st, cnt, ind, b, sr);
            checks++; if (depth !== 4'(m_depth) || push_ready !== (m_depth < LC) || err !== m_err)
                begin errors++; $display("FAIL rand_ctl%0d got depth=%0d ready=%b err=%b want %0d %b %b", i, depth, push_ready, err, m_depth, m_depth < LC, m_err); end
            checks++; if (addr !== exp_addr() || done !== exp_done())
                begin errors++; $display("FAIL rand_out%0d got addr=%h done=%b want %h %b", i, addr, done, exp_addr(), exp_done()); end
            if (!top_exhausted()) begin
                checks++; if (copy_count !== exp_cc())
                    begin errors++; $display("FAIL rand_cc%0d got %0d want %0d", i, copy_count, exp_cc()); end
            end
        end
    endtask

`ifdef LOOP_STACK_PERF_EN
    task automatic test_perf();
        do_reset();
        tick(0, 0, 1, 0, 10, 1, pack3(0, 0, 0), pack3(1, 1, 1));
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0, 0, '0, '0);
        checks++; if (perf_issued !== 32'd10 || perf_stall !== 32'd5)
            begin errors++; $display("FAIL perf got issued=%0d stall=%0d want 10 5", perf_issued, perf_stall); end
        checks++; if (perf_issued !== m_issued || perf_stall !== m_stalls)
            begin errors++; $display("FAIL perf_model got issued=%0d stall=%0d want %0d %0d", perf_issued, perf_stall, m_issued, m_stalls); end
    endtask
`endif

    initial begin
        reset = 1'b1; stall = 0; push = 0; pop = 0; step = 0;
        push_count = '0; push_independent = 0; push_base = '0; push_stride = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_independent();
        test_nested();
        test_overflow();
        test_replace_stall();
        test_random();
`ifdef LOOP_STACK_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_stack_agu.md
Name: loop_stack_agu

Overview:
- Next-generation nested-loop manager for the control unit.
- Holds a stack of up to 2^LOOP_LOG_CNT loop levels. Each level carries an iteration counter and ADDR_CH address accumulators, each with its own stride.
- Emits the superscalar copy count and the current addresses for the innermost loop.
- Sits between instruction decode (push/pop/step commands) and the instruction queue (stall).

Parameters:
- BITS, 18, iteration counter width.
- LOOP_LOG_CNT, 3, log2 of stack depth; LOOP_CNT = 1<<LOOP_LOG_CNT.
- SUPERSCALAR_LOG_WIDTH, 2, log2 of issue width; W = 1<<SUPERSCALAR_LOG_WIDTH.
- ADDR_BITS, 18, address/stride width.
- ADDR_CH, 3, address streams per loop level.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  freeze all state this cycle; commands are ignored
- push  in  1  create a new innermost loop
- push_count  in  BITS  iteration count of the new loop; must be nonzero
- push_independent  in  1  new loop is an inner independent loop (superscalar copies)
- push_base  in  ADDR_CH*ADDR_BITS  initial addresses
- push_stride  in  ADDR_CH*ADDR_BITS  per-iteration strides
- step  in  1  top loop body issued; advance the iteration
- pop  in  1  top loop finished; remove it
- push_ready  out  1  depth < LOOP_CNT
- depth  out  LOOP_LOG_CNT+1  number of live levels
- done  out  1  top loop is on its last issue group
- copy_count  out  SUPERSCALAR_LOG_WIDTH  copies-1 for the current issue group
- addr  out  ADDR_CH*ADDR_BITS  addresses of the top level for copy 0
- err  out  1  sticky: overflow push, zero-count push, or pop/step while empty

Behaviour:
- Reset: depth=0, err=0, all levels cleared. While empty, done=0, copy_count=0, addr=0.
- Outputs are combinational from the top-of-stack registers (level depth-1), so they have zero-cycle latency after a state update.
- Command priority per unstalled cycle is pop > push > step. Lower-priority commands in the same cycle are ignored, except that pop+push replaces the top: the pop is applied, then the push lands at the same depth.
- push accepted (push && push_ready && push_count!=0), written into level[depth]:
  - rem=push_count; ind=push_independent; acc[c]=base[c]; str[c]=stride[c]; depth+1.
- push rejected: if depth==LOOP_CNT or push_count==0, set err and leave the state unchanged.
- step, top level (depth>0): n = ind ? min(rem, W) : 1.
  - rem -= n.
  - acc[c] += str[c]*n, truncated to ADDR_BITS (modulo wrap); n*stride may use a shift-add.
  - If rem would reach 0, the counter saturates at 0; the level stays live until pop.
- Outer levels are never modified by step. Their accumulators resume from their own values after the inner loop pops.
- done = ind ? (rem <= W) : (rem == 1). done=0 when rem==0.
- copy_count = ind ? min(rem, W)-1 : 0.
- pop with depth>0: depth-1. The vacated level's content is don't-care.
- pop or step with depth==0: set err, no state change.
- stall=1: no state change, and err is not set by commands presented that cycle.
- reset mid-operation drops all levels in one cycle.

Optional Feature:
- Macro: LOOP_STACK_PERF_EN.
- When defined, adds two outputs:
  - perf_issued (32 bits): total copies issued, i.e. the sum of n over accepted steps.
  - perf_stall (32 bits): count of cycles with stall=1.
- Both counters clear on reset and wrap at 2^32.
- When not defined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package loop_pkg:
  - constant derivations (LOOP_CNT, W);
  - a min-with-W function;
  - a typedef of the level record {rem, ind, acc[ADDR_CH], str[ADDR_CH]}.
- One sub-module, loop_level: holds a single stack entry, with load, step and n-compute. It is instantiated LOOP_CNT times; the top-level module muxes by depth.

Test Plan:
- Reset, then push count=3, ind=0, base=100, stride=4; step x3. Expect addr 100→104→108→112, done=1 only when rem==1 (after 2 steps), copy_count=0 throughout; pop → depth=0.
- Push count=10, ind=1, W=4. Expect copy_count 3,3,1 across steps with rem 10→6→2→0; done asserted at rem=2; addr advances by 4*stride, 4*stride, 2*stride.
- Push outer count=2, base=0, stride=100; push inner count=2, base=7, stride=1; step, step, pop. Expect outer addr still 0; one outer step → 100, depth 1.
- Push 8 levels: push_ready=0. A 9th push sets err with depth=8; pop with an empty stack (after 8 pops) also sets err.
- pop+push in the same cycle at depth=2 leaves depth=2 with the new loop's base on addr. push_count=0 sets err with no depth change. stall=1 with step holds rem and addr.
- With LOOP_STACK_PERF_EN: the count=10/ind=1 sequence plus 5 stall cycles gives perf_issued=10 and perf_stall=5.
